// File: rtl/mem_uart_tx_if.sv
// Store-bus interface between the core's memory stage and mem_uart_tx.
//   wr_en    : one-cycle store strobe; mem_addr/mem_data valid when high
//   mem_addr : store address
//   mem_data : store data
// master drives the bus (core / testbench), slave consumes it (peripheral).
interface mem_uart_tx_if;
  logic        wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;

  modport master (output wr_en, output mem_addr, output mem_data);
  modport slave  (input  wr_en, input  mem_addr, input  mem_data);
endinterface

// File: rtl/mem_uart_tx.sv
// mem_uart_tx: memory-mapped character output. Stores to TX_ADDR push the low
// data byte into a FIFO; an 8N1 UART transmitter drains the FIFO onto o_tx.
// Bytes arriving while the FIFO is full are dropped and flagged in o_overflow,
// which is cleared by a store to STAT_ADDR with data bit 0 set.
//
// Ports:
//   i_clk      : single clock
//   i_reset_n  : asynchronous reset, active low
//   bus        : store bus (wr_en, mem_addr, mem_data), slave side
//   o_tx       : UART serial line, idle high, registered
//   o_busy     : transmitter active or FIFO non-empty
//   o_level    : FIFO occupancy
//   o_overflow : sticky, a byte was dropped
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high); on expiry chains straight into the next frame
module mem_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = 32'h0000_1000,
  parameter logic [31:0] STAT_ADDR    = 32'h0000_1004
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  mem_uart_tx_if.slave                  bus,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  baud_cnt, baud_cnt_n;
  logic [2:0]     bit_idx, bit_idx_n;
  logic [7:0]     shift, shift_n;
  logic           tx, tx_n;

  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  level;
  logic           overflow;

  logic           push_req;
  logic           clr_req;
  logic           push_acc;
  logic           drop;
  logic           pop;
  logic           baud_done;
  logic           fifo_nonempty;

  // Only the low byte of a store is transmitted.
  logic           unused_data_hi;
  assign unused_data_hi = ^bus.mem_data[31:8];

  assign push_req      = bus.wr_en && (bus.mem_addr == TX_ADDR);
  assign clr_req       = bus.wr_en && (bus.mem_addr == STAT_ADDR) && bus.mem_data[0];
  assign baud_done     = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign fifo_nonempty = (level != '0);

  // A pop happens whenever the transmitter is ready for a new frame and the
  // FIFO holds a byte: from IDLE, or at the end of a stop bit.
  assign pop = fifo_nonempty &&
               ((state == IDLE) || ((state == STOP) && baud_done));

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_acc = push_req && ((level < LW'(FIFO_DEPTH)) || pop);
  assign drop     = push_req && !push_acc;

  // FIFO storage; the head is read before the same-edge write, so a push
  // into the slot being popped at full never corrupts the popped byte.
  always_ff @(posedge i_clk) begin
    if (push_acc) begin
      fifo_mem[wr_ptr] <= bus.mem_data[7:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      level <= level + LW'(push_acc) - LW'(pop);
      // A drop in the same cycle as a clear wins.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_req) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      tx       <= tx_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    tx_n       = tx;

    if (pop) begin
      shift_n = fifo_mem[rd_ptr];
    end

    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (pop) begin
          state_n    = START;
          baud_cnt_n = '0;
          tx_n       = 1'b0;
        end
      end

      START: begin
        if (baud_done) begin
          state_n    = DATA;
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          tx_n       = shift[0];
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shift[bit_idx + 3'd1];
          end
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end

      STOP: begin
        if (baud_done) begin
          baud_cnt_n = '0;
          if (pop) begin
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end

      default: begin
        state_n    = IDLE;
        baud_cnt_n = '0;
        tx_n       = 1'b1;
      end
    endcase
  end

  assign o_tx       = tx;
  assign o_level    = level;
  assign o_overflow = overflow;
  assign o_busy     = (state != IDLE) || fifo_nonempty;

endmodule

// File: tb/tb_mem_uart_tx.sv
module tb_mem_uart_tx;

  localparam int          CPB    = 4;
  localparam int          DEPTH  = 8;
  localparam int          FRAME  = 10 * CPB;
  localparam logic [31:0] TX_A   = 32'h0000_1000;
  localparam logic [31:0] STAT_A = 32'h0000_1004;

  logic       clk;
  logic       rst_n;
  logic       o_tx;
  logic       o_busy;
  logic [3:0] o_level;
  logic       o_overflow;

  mem_uart_tx_if bus ();

  mem_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .TX_ADDR      (TX_A),
    .STAT_ADDR    (STAT_A)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .bus        (bus),
    .o_tx       (o_tx),
    .o_busy     (o_busy),
    .o_level    (o_level),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: a byte queue plus the timeline of the frame on the line.
  logic [7:0] mq[$];
  logic [7:0] exp_bytes[$];
  int         e;
  int         next_ok;
  int         frame_start;
  logic       have_frame;
  logic [7:0] cur_byte;
  logic       m_ovf;

  // Line decoder: samples each bit mid-cell on falling clock edges.
  logic [7:0] dec_data[$];
  logic       dec_stop[$];
  time        dec_start[$];

  initial begin : decoder
    logic [7:0] b;
    time        t0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && o_tx === 1'b0) begin
        t0 = $time;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = o_tx;
        end
        repeat (CPB) @(negedge clk);
        dec_data.push_back(b);
        dec_stop.push_back(o_tx);
        dec_start.push_back(t0);
        @(negedge clk);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic model_tx();
    int k;
    if (!have_frame || e >= frame_start + FRAME) return 1'b1;
    k = (e - frame_start) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return cur_byte[k-1];
  endfunction

  task automatic model_reset();
    mq.delete();
    next_ok    = 0;
    have_frame = 1'b0;
    m_ovf      = 1'b0;
  endtask

  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
    int   lvl;
    logic pop;
    logic drop;
    bus.wr_en    = we;
    bus.mem_addr = a;
    bus.mem_data = d;
    @(posedge clk);
    e++;
    lvl = mq.size();
    pop = (lvl > 0) && (e >= next_ok);
    if (pop) begin
      cur_byte    = mq.pop_front();
      frame_start = e;
      next_ok     = e + FRAME;
      have_frame  = 1'b1;
      exp_bytes.push_back(cur_byte);
    end
    drop = 1'b0;
    if (we && a == TX_A) begin
      if (lvl < DEPTH || pop) mq.push_back(d[7:0]);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (we && a == STAT_A && d[0]) m_ovf = 1'b0;
    #1;
    bus.wr_en = 1'b0;
    chk("tx", 32'(o_tx), 32'(model_tx()));
    chk("level", 32'(o_level), mq.size());
    chk("busy", 32'(o_busy), 32'((e < next_ok) || (mq.size() > 0)));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && !(mq.size() == 0 && e >= next_ok); i++) idle(1);
    chk("drain_done", 32'(mq.size() == 0 && e >= next_ok), 32'd1);
    idle(4);
  endtask

  task automatic check_decoded();
    chk("dec_count", dec_data.size(), exp_bytes.size());
    for (int i = 0; i < dec_data.size() && i < exp_bytes.size(); i++) begin
      chk("dec_byte", 32'(dec_data[i]), 32'(exp_bytes[i]));
      chk("dec_stop", 32'(dec_stop[i]), 32'd1);
    end
  endtask

  task automatic clear_logs();
    dec_data.delete();
    dec_stop.delete();
    dec_start.delete();
    exp_bytes.delete();
  endtask

  initial begin : stim
    int n;
    int sel;
    logic [31:0] a;
    e = 0;
    model_reset();
    bus.wr_en    = 1'b0;
    bus.mem_addr = '0;
    bus.mem_data = '0;

    // reset state
    rst_n = 1'b0;
    #12;
    chk("rst_tx", 32'(o_tx), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_level", 32'(o_level), 32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single frame 0x55
    step(1'b1, TX_A, 32'h0000_0055);
    chk("first_level", 32'(o_level), 32'd1);
    chk("first_tx_idle", 32'(o_tx), 32'd1);
    idle(1);
    chk("first_tx_start", 32'(o_tx), 32'd0);
    chk("first_level_popped", 32'(o_level), 32'd0);
    idle(FRAME + 5);
    chk("first_busy_end", 32'(o_busy), 32'd0);
    check_decoded();
    chk("first_byte", 32'(dec_data[0]), 32'h55);

    // back-to-back frames
    step(1'b1, TX_A, 32'h0000_00A5);
    step(1'b1, TX_A, 32'hFFFF_FF3C);
    idle(2 * FRAME + 6);
    check_decoded();
    n = dec_data.size();
    if (n >= 2) begin
      chk("b2b_first", 32'(dec_data[n-2]), 32'hA5);
      chk("b2b_second", 32'(dec_data[n-1]), 32'h3C);
      chk("b2b_gap", 32'(dec_start[n-1] - dec_start[n-2]), 32'(FRAME * 10));
    end else begin
      chk("b2b_frames", n, 2);
    end

    // other addresses ignored
    step(1'b1, 32'h0000_2000, 32'h0000_0041);
    step(1'b1, STAT_A, 32'h0000_0040);
    idle(6);
    chk("ignored_level", 32'(o_level), 32'd0);
    chk("ignored_tx", 32'(o_tx), 32'd1);

    // overflow: 10 stores back-to-back
    for (int i = 0; i < 10; i++) step(1'b1, TX_A, 32'($urandom_range(0, 255)));
    chk("ovf_level", 32'(o_level), 32'd8);
    chk("ovf_flag", 32'(o_overflow), 32'd1);
    step(1'b1, STAT_A, 32'h0000_0001);
    chk("ovf_cleared", 32'(o_overflow), 32'd0);
    // store landing exactly on the pop edge while full
    for (int i = 0; i < 200 && e < next_ok - 1; i++) idle(1);
    step(1'b1, TX_A, 32'h0000_007E);
    chk("full_pop_level", 32'(o_level), 32'd8);
    chk("full_pop_ovf", 32'(o_overflow), 32'd0);
    step(1'b1, STAT_A, 32'h0000_0001);
    chk("stat_clear", 32'(o_overflow), 32'd0);
    drain();
    check_decoded();

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) a = 32'h0000_2000 + 32'($urandom_range(0, 15)) * 4;
      else if (sel == 1) a = STAT_A;
      else a = TX_A;
      step(1'b1, a, $urandom);
      idle(int'($urandom_range(0, 25)));
    end
    drain();
    check_decoded();

    // asynchronous reset in the middle of DATA
    step(1'b1, TX_A, 32'h0000_005A);
    for (int i = 0; i < 100 && !(have_frame && e >= frame_start + 3 * CPB); i++) idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(o_tx), 32'd1);
    chk("midrst_level", 32'(o_level), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    idle(FRAME + 10);
    clear_logs();
    step(1'b1, TX_A, 32'h0000_00C3);
    idle(FRAME + 5);
    check_decoded();
    if (dec_data.size() > 0) chk("post_rst_byte", 32'(dec_data[0]), 32'hC3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
